// File: rtl/cw305_reg_mailbox.sv
// Host-register mailbox: host->core TX FIFO, core->host RX FIFO, core reset pulse.
// Optional sticky error register enabled by defining CW305_MBOX_ERR_EN.
module cw305_reg_mailbox #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pDEPTH        = 16,
    parameter int pRST_CYCLES   = 64
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_n,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    input  logic [7:0]                           write_data,
    output logic [7:0]                           read_data,
    input  logic                                 reg_read,
    input  logic                                 reg_write,
    input  logic                                 reg_addrvalid,
    output logic [7:0]                           O_tx_data,
    output logic                                 O_tx_valid,
    input  logic                                 I_tx_ready,
    input  logic [7:0]                           I_rx_data,
    input  logic                                 I_rx_valid,
    output logic                                 O_rx_ready,
    output logic                                 O_reset
);

    localparam int RAW = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int AW  = $clog2(pDEPTH);
    localparam int CW  = AW + 1;

    localparam logic [RAW-1:0] ADDR_TX_DATA  = RAW'(8'h00);
    localparam logic [RAW-1:0] ADDR_RX_DATA  = RAW'(8'h01);
    localparam logic [RAW-1:0] ADDR_STATUS   = RAW'(8'h02);
    localparam logic [RAW-1:0] ADDR_TX_COUNT = RAW'(8'h03);
    localparam logic [RAW-1:0] ADDR_RX_COUNT = RAW'(8'h04);
    localparam logic [RAW-1:0] ADDR_RESET    = RAW'(8'h05);
    localparam logic [RAW-1:0] ADDR_CTRL     = RAW'(8'h06);
    localparam logic [RAW-1:0] ADDR_ERR      = RAW'(8'h07);

    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(pDEPTH);
    localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [15:0]   RST_LOAD = 16'(pRST_CYCLES - 1);

    logic [7:0]    tx_mem_r [pDEPTH];
    logic [7:0]    rx_mem_r [pDEPTH];
    logic [AW-1:0] tx_wp_r, tx_rp_r, rx_wp_r, rx_rp_r;
    logic [AW-1:0] tx_wp_nxt_s, tx_rp_nxt_s, rx_wp_nxt_s, rx_rp_nxt_s;
    logic [CW-1:0] tx_cnt_r, rx_cnt_r, tx_cnt_nxt_s, rx_cnt_nxt_s;
    logic [7:0]    read_data_r, rd_val_s, err_rd_s;
    logic [15:0]   rst_cnt_r, rst_cnt_nxt_s;
    logic          rst_pulse_r, rst_pulse_nxt_s;
    logic          rx_ready_r, rx_ready_nxt_s;
    logic          reg_read_q_r;

    logic wr_en_s, rd_en_s, ctrl_wr_s, rst_wr_s, rst_start_s;
    logic tx_empty_s, tx_full_s, tx_push_req_s, tx_push_s, tx_pop_s, tx_flush_s;
    logic rx_empty_s, rx_full_s, rx_push_s, rx_pop_s, rx_flush_s, rd_first_s;
    logic unused_s;

    assign unused_s = &{1'b0, reg_bytecnt};

    assign wr_en_s     = reg_write & reg_addrvalid;
    assign rd_en_s     = reg_read & reg_addrvalid;
    assign ctrl_wr_s   = wr_en_s & (reg_address == ADDR_CTRL);
    assign rst_wr_s    = wr_en_s & (reg_address == ADDR_RESET);
    assign rst_start_s = rst_wr_s & (write_data != 8'h00);

    assign tx_empty_s    = (tx_cnt_r == CNT_ZERO);
    assign tx_full_s     = (tx_cnt_r == CNT_FULL);
    assign tx_pop_s      = ~tx_empty_s & I_tx_ready;
    assign tx_push_req_s = wr_en_s & (reg_address == ADDR_TX_DATA);
    assign tx_push_s     = tx_push_req_s & (~tx_full_s | tx_pop_s) & ~rst_pulse_r;
    // A starting reset pulse flushes immediately so the FIFOs read empty for its whole duration.
    assign tx_flush_s    = (ctrl_wr_s & write_data[0]) | rst_pulse_r | rst_start_s;

    assign rx_empty_s = (rx_cnt_r == CNT_ZERO);
    assign rx_full_s  = (rx_cnt_r == CNT_FULL);
    assign rx_push_s  = I_rx_valid & rx_ready_r;
    assign rd_first_s = rd_en_s & (reg_address == ADDR_RX_DATA) & ~reg_read_q_r;
    assign rx_pop_s   = rd_first_s & ~rx_empty_s;
    assign rx_flush_s = (ctrl_wr_s & write_data[1]) | rst_pulse_r | rst_start_s;

    assign O_tx_valid = ~tx_empty_s;
    assign O_tx_data  = tx_empty_s ? 8'h00 : tx_mem_r[tx_rp_r];
    assign O_rx_ready = rx_ready_r;
    assign O_reset    = rst_pulse_r;
    assign read_data  = read_data_r;

    // TX FIFO next-state: flush overrides push/pop.
    always_comb begin
        tx_wp_nxt_s  = tx_wp_r;
        tx_rp_nxt_s  = tx_rp_r;
        tx_cnt_nxt_s = tx_cnt_r;
        if (tx_flush_s) begin
            tx_wp_nxt_s  = PTR_ZERO;
            tx_rp_nxt_s  = PTR_ZERO;
            tx_cnt_nxt_s = CNT_ZERO;
        end else begin
            if (tx_push_s) tx_wp_nxt_s = tx_wp_r + PTR_ONE;
            else           tx_wp_nxt_s = tx_wp_r;
            if (tx_pop_s)  tx_rp_nxt_s = tx_rp_r + PTR_ONE;
            else           tx_rp_nxt_s = tx_rp_r;
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_cnt_nxt_s = tx_cnt_r + CNT_ONE;
                2'b01:   tx_cnt_nxt_s = tx_cnt_r - CNT_ONE;
                default: tx_cnt_nxt_s = tx_cnt_r;
            endcase
        end
    end

    // RX FIFO next-state: flush overrides push/pop.
    always_comb begin
        rx_wp_nxt_s  = rx_wp_r;
        rx_rp_nxt_s  = rx_rp_r;
        rx_cnt_nxt_s = rx_cnt_r;
        if (rx_flush_s) begin
            rx_wp_nxt_s  = PTR_ZERO;
            rx_rp_nxt_s  = PTR_ZERO;
            rx_cnt_nxt_s = CNT_ZERO;
        end else begin
            if (rx_push_s) rx_wp_nxt_s = rx_wp_r + PTR_ONE;
            else           rx_wp_nxt_s = rx_wp_r;
            if (rx_pop_s)  rx_rp_nxt_s = rx_rp_r + PTR_ONE;
            else           rx_rp_nxt_s = rx_rp_r;
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_cnt_nxt_s = rx_cnt_r + CNT_ONE;
                2'b01:   rx_cnt_nxt_s = rx_cnt_r - CNT_ONE;
                default: rx_cnt_nxt_s = rx_cnt_r;
            endcase
        end
    end

    // Core reset pulse counter: any host write to RESET takes priority over the countdown.
    always_comb begin
        rst_pulse_nxt_s = rst_pulse_r;
        rst_cnt_nxt_s   = rst_cnt_r;
        if (rst_start_s) begin
            rst_pulse_nxt_s = 1'b1;
            rst_cnt_nxt_s   = RST_LOAD;
        end else if (rst_wr_s) begin
            rst_pulse_nxt_s = 1'b0;
            rst_cnt_nxt_s   = 16'h0000;
        end else if (rst_pulse_r) begin
            if (rst_cnt_r == 16'h0000) begin
                rst_pulse_nxt_s = 1'b0;
                rst_cnt_nxt_s   = 16'h0000;
            end else begin
                rst_pulse_nxt_s = 1'b1;
                rst_cnt_nxt_s   = rst_cnt_r - 16'h0001;
            end
        end else begin
            rst_pulse_nxt_s = 1'b0;
            rst_cnt_nxt_s   = 16'h0000;
        end
    end

    // Ready is registered from next state so it already reflects this cycle's flush/push/pop.
    assign rx_ready_nxt_s = (rx_cnt_nxt_s != CNT_FULL) & ~rst_pulse_nxt_s;

    // Host read mux; later cycles of an RX_DATA burst hold the byte popped on the first.
    always_comb begin
        rd_val_s = 8'h00;
        if (rd_en_s) begin
            case (reg_address)
                ADDR_RX_DATA: begin
                    if (rd_first_s) begin
                        if (rx_empty_s) rd_val_s = 8'h00;
                        else            rd_val_s = rx_mem_r[rx_rp_r];
                    end else begin
                        rd_val_s = read_data_r;
                    end
                end
                ADDR_STATUS:   rd_val_s = {3'b000, rst_pulse_r, rx_full_s, rx_empty_s, tx_full_s, tx_empty_s};
                ADDR_TX_COUNT: rd_val_s = 8'(tx_cnt_r);
                ADDR_RX_COUNT: rd_val_s = 8'(rx_cnt_r);
                ADDR_RESET:    rd_val_s = {7'b0000000, rst_pulse_r};
                ADDR_ERR:      rd_val_s = err_rd_s;
                default:       rd_val_s = 8'h00;
            endcase
        end else begin
            rd_val_s = 8'h00;
        end
    end

`ifdef CW305_MBOX_ERR_EN
    logic [1:0] err_r, err_set_s, err_clr_s, err_nxt_s;

    assign err_set_s = {rd_first_s & rx_empty_s,
                        tx_push_req_s & tx_full_s & ~tx_pop_s & ~rst_pulse_r};
    assign err_clr_s = (wr_en_s && (reg_address == ADDR_ERR)) ? write_data[1:0] : 2'b00;
    assign err_nxt_s = (err_r & ~err_clr_s) | err_set_s;
    assign err_rd_s  = {6'b000000, err_r};

    // Sticky error flags; a new event wins over a same-cycle clear.
    always_ff @(posedge usb_clk) begin
        if (!reset_n) err_r <= 2'b00;
        else          err_r <= err_nxt_s;
    end
`else
    assign err_rd_s = 8'h00;
`endif

    // Control and status registers.
    always_ff @(posedge usb_clk) begin
        if (!reset_n) begin
            tx_wp_r      <= PTR_ZERO;
            tx_rp_r      <= PTR_ZERO;
            tx_cnt_r     <= CNT_ZERO;
            rx_wp_r      <= PTR_ZERO;
            rx_rp_r      <= PTR_ZERO;
            rx_cnt_r     <= CNT_ZERO;
            rst_pulse_r  <= 1'b0;
            rst_cnt_r    <= 16'h0000;
            rx_ready_r   <= 1'b0;
            read_data_r  <= 8'h00;
            reg_read_q_r <= 1'b0;
        end else begin
            tx_wp_r      <= tx_wp_nxt_s;
            tx_rp_r      <= tx_rp_nxt_s;
            tx_cnt_r     <= tx_cnt_nxt_s;
            rx_wp_r      <= rx_wp_nxt_s;
            rx_rp_r      <= rx_rp_nxt_s;
            rx_cnt_r     <= rx_cnt_nxt_s;
            rst_pulse_r  <= rst_pulse_nxt_s;
            rst_cnt_r    <= rst_cnt_nxt_s;
            rx_ready_r   <= rx_ready_nxt_s;
            read_data_r  <= rd_val_s;
            reg_read_q_r <= reg_read;
        end
    end

    // FIFO storage; left unreset because occupancy gates every read of it.
    always_ff @(posedge usb_clk) begin
        if (tx_push_s) tx_mem_r[tx_wp_r] <= write_data;
        if (rx_push_s) rx_mem_r[rx_wp_r] <= I_rx_data;
    end

endmodule

// File: tb/tb_cw305_reg_mailbox.sv
// Directed, table-driven bench for cw305_reg_mailbox (default parameters).
module tb_cw305_reg_mailbox;

    logic        usb_clk = 1'b0;
    logic        reset_n;
    logic [13:0] reg_address;
    logic [6:0]  reg_bytecnt;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        reg_read, reg_write, reg_addrvalid;
    logic [7:0]  O_tx_data;
    logic        O_tx_valid;
    logic        I_tx_ready;
    logic [7:0]  I_rx_data;
    logic        I_rx_valid;
    logic        O_rx_ready;
    logic        O_reset;

    int total = 0;
    int bad   = 0;

`ifdef CW305_MBOX_ERR_EN
    localparam logic [7:0] E_TX = 8'h01;
    localparam logic [7:0] E_RX = 8'h02;
`else
    localparam logic [7:0] E_TX = 8'h00;
    localparam logic [7:0] E_RX = 8'h00;
`endif

    cw305_reg_mailbox dut (
        .usb_clk(usb_clk), .reset_n(reset_n), .reg_address(reg_address),
        .reg_bytecnt(reg_bytecnt), .write_data(write_data), .read_data(read_data),
        .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
        .O_tx_data(O_tx_data), .O_tx_valid(O_tx_valid), .I_tx_ready(I_tx_ready),
        .I_rx_data(I_rx_data), .I_rx_valid(I_rx_valid), .O_rx_ready(O_rx_ready),
        .O_reset(O_reset)
    );

    always #5 usb_clk = ~usb_clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [13:0] addr;
        logic [7:0]  wdata;
        logic        txr;
        logic        rxv;
        logic [7:0]  rxd;
        logic [7:0]  exp_rd;
        logic        exp_txv;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v_wr(input logic [13:0] a, input logic [7:0] d,
                                  input logic txv, input logic [7:0] txd);
        vec_t v = '{1'b1, 1'b0, a, d, 1'b0, 1'b0, 8'h00, 8'h00, txv, txd};
        return v;
    endfunction

    function automatic vec_t v_rd(input logic [13:0] a, input logic [7:0] e,
                                  input logic txv, input logic [7:0] txd);
        vec_t v = '{1'b0, 1'b1, a, 8'h00, 1'b0, 1'b0, 8'h00, e, txv, txd};
        return v;
    endfunction

    function automatic vec_t v_idle(input logic txr, input logic rxv, input logic [7:0] rxd,
                                    input logic txv, input logic [7:0] txd);
        vec_t v = '{1'b0, 1'b0, 14'h0000, 8'h00, txr, rxv, rxd, 8'h00, txv, txd};
        return v;
    endfunction

    task automatic step();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic bus_idle();
        reg_read = 1'b0; reg_write = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic reg_wr(input logic [13:0] a, input logic [7:0] d);
        reg_address = a; write_data = d; reg_write = 1'b1; reg_addrvalid = 1'b1;
        step();
        bus_idle();
    endtask

    task automatic reg_rd(input logic [13:0] a, input logic [7:0] e, input string name);
        reg_address = a; reg_read = 1'b1; reg_addrvalid = 1'b1;
        step();
        check8(name, read_data, e);
        bus_idle();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset_n = 1'b0; reg_bytecnt = 7'h00; write_data = 8'h00; reg_address = 14'h0002;
        reg_read = 1'b1; reg_addrvalid = 1'b1; reg_write = 1'b0;
        I_tx_ready = 1'b0; I_rx_valid = 1'b0; I_rx_data = 8'h00;
        step(); step();
        check8("rst_read_data", read_data, 8'h00);
        check8("rst_o_reset", {7'd0, O_reset}, 8'h00);
        check8("rst_tx_valid", {7'd0, O_tx_valid}, 8'h00);
        check8("rst_rx_ready", {7'd0, O_rx_ready}, 8'h00);
        reset_n = 1'b1; bus_idle();
        step();
        check8("rx_ready_after_rst", {7'd0, O_rx_ready}, 8'h01);

        // Single-cycle vectors: TX ordering, register map, RX pops, ERR, RX flush.
        vecs.push_back(v_rd(14'h02, 8'h05, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_wr(14'h00, 8'hA1, 1'b1, 8'hA1));
        vecs.push_back(v_wr(14'h00, 8'hB2, 1'b1, 8'hA1));
        vecs.push_back(v_wr(14'h00, 8'hC3, 1'b1, 8'hA1));
        vecs.push_back(v_rd(14'h03, 8'h03, 1'b1, 8'hA1));
        vecs.push_back(v_idle(1'b1, 1'b0, 8'h00, 1'b1, 8'hB2));
        vecs.push_back(v_idle(1'b1, 1'b0, 8'h00, 1'b1, 8'hC3));
        vecs.push_back(v_idle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h03, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h05, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h08, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_wr(14'h08, 8'hFF, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h07, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b1, 8'h55, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b1, 8'h66, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h04, 8'h02, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h01, 8'h55, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h04, 8'h01, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h01, 8'h66, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h01, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h07, E_RX, 1'b0, 8'h00));
        vecs.push_back(v_wr(14'h07, 8'h02, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h07, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b1, 8'h77, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b1, 8'h88, 1'b0, 8'h00));
        vecs.push_back(v_wr(14'h06, 8'h02, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h04, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h02, 8'h05, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b1, 8'h99, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h01, 8'h99, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h00, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_rd(14'h06, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v_idle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00));

        foreach (vecs[i]) begin
            reg_write = vecs[i].wr; reg_read = vecs[i].rd;
            reg_addrvalid = vecs[i].wr | vecs[i].rd;
            reg_address = vecs[i].addr; write_data = vecs[i].wdata;
            I_tx_ready = vecs[i].txr; I_rx_valid = vecs[i].rxv; I_rx_data = vecs[i].rxd;
            step();
            check8($sformatf("vec%0d_read_data", i), read_data, vecs[i].exp_rd);
            check8($sformatf("vec%0d_tx_valid", i), {7'd0, O_tx_valid}, {7'd0, vecs[i].exp_txv});
            if (vecs[i].exp_txv) check8($sformatf("vec%0d_tx_data", i), O_tx_data, vecs[i].exp_txd);
        end
        bus_idle(); I_tx_ready = 1'b0; I_rx_valid = 1'b0;

        // TX overflow: 17 writes into 16 entries, 17th byte lost.
        for (int i = 0; i < 17; i++) begin
            reg_address = 14'h00; write_data = 8'(16 + i); reg_write = 1'b1; reg_addrvalid = 1'b1;
            step();
        end
        bus_idle();
        reg_rd(14'h02, 8'h06, "ovf_status");
        reg_rd(14'h03, 8'h10, "ovf_tx_count");
        reg_rd(14'h07, E_TX, "ovf_err");
        for (int i = 0; i < 16; i++) begin
            I_tx_ready = 1'b1;
            check8($sformatf("drain%0d_valid", i), {7'd0, O_tx_valid}, 8'h01);
            check8($sformatf("drain%0d_data", i), O_tx_data, 8'(16 + i));
            step();
        end
        I_tx_ready = 1'b0;
        check8("drain_empty", {7'd0, O_tx_valid}, 8'h00);
        reg_wr(14'h07, 8'h03);

        // Three-cycle RX_DATA burst pops only once.
        I_rx_valid = 1'b1; I_rx_data = 8'h55; step();
        I_rx_data = 8'h66; step();
        I_rx_valid = 1'b0;
        reg_address = 14'h01; reg_read = 1'b1; reg_addrvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check8($sformatf("burst%0d", k), read_data, 8'h55);
        end
        bus_idle(); step();
        check8("burst_end", read_data, 8'h00);
        reg_rd(14'h04, 8'h01, "burst_rx_count");
        reg_rd(14'h01, 8'h66, "burst_second");
        reg_rd(14'h01, 8'h00, "burst_underflow");
        reg_rd(14'h07, E_RX, "burst_err");
        reg_wr(14'h07, 8'h03);
        reg_rd(14'h07, 8'h00, "err_cleared");

        // Reset pulse length, restart, dropped traffic, early clear.
        reg_wr(14'h05, 8'h01);
        cnt = 0;
        while (O_reset === 1'b1 && cnt < 200) begin cnt++; step(); end
        check_int("pulse_len", cnt, 64);
        reg_wr(14'h05, 8'h01);
        cnt = 0;
        while (O_reset === 1'b1 && cnt < 300) begin
            cnt++;
            if (cnt == 30) begin
                reg_address = 14'h05; write_data = 8'h01; reg_write = 1'b1; reg_addrvalid = 1'b1;
            end else begin
                bus_idle();
            end
            step();
        end
        bus_idle();
        check_int("pulse_restart_len", cnt, 94);
        reg_wr(14'h05, 8'h01);
        check8("pulse_on", {7'd0, O_reset}, 8'h01);
        check8("pulse_rx_ready", {7'd0, O_rx_ready}, 8'h00);
        reg_rd(14'h02, 8'h15, "pulse_status");
        reg_wr(14'h00, 8'hEE);
        I_rx_valid = 1'b1; I_rx_data = 8'h12; step(); I_rx_valid = 1'b0;
        reg_rd(14'h03, 8'h00, "pulse_tx_drop");
        reg_rd(14'h04, 8'h00, "pulse_rx_drop");
        reg_rd(14'h05, 8'h01, "pulse_reset_reg");
        reg_wr(14'h05, 8'h00);
        check8("pulse_cleared", {7'd0, O_reset}, 8'h00);
        check8("pulse_cleared_rdy", {7'd0, O_rx_ready}, 8'h01);

        // Simultaneous push/pop keeps count; flush beats same-cycle pop.
        for (int i = 0; i < 4; i++) reg_wr(14'h00, 8'(8'h31 + i));
        reg_address = 14'h00; write_data = 8'h35; reg_write = 1'b1; reg_addrvalid = 1'b1;
        I_tx_ready = 1'b1; step(); bus_idle(); I_tx_ready = 1'b0;
        check8("pushpop_head", O_tx_data, 8'h32);
        reg_rd(14'h03, 8'h04, "pushpop_count");
        reg_address = 14'h06; write_data = 8'h01; reg_write = 1'b1; reg_addrvalid = 1'b1;
        I_tx_ready = 1'b1; step(); bus_idle(); I_tx_ready = 1'b0;
        check8("flush_tx_valid", {7'd0, O_tx_valid}, 8'h00);
        reg_rd(14'h03, 8'h00, "flush_tx_count");

        // reset_n with data held, then reset_n in the middle of a pulse.
        for (int i = 0; i < 5; i++) begin
            I_rx_valid = 1'b1; I_rx_data = 8'(8'h41 + i); step();
        end
        I_rx_valid = 1'b0;
        reg_wr(14'h00, 8'hC7);
        reg_wr(14'h00, 8'hC8);
        reg_rd(14'h04, 8'h05, "pre_rst_rx_count");
        reset_n = 1'b0; reg_address = 14'h04; reg_read = 1'b1; reg_addrvalid = 1'b1;
        step();
        check8("hrst_read_data", read_data, 8'h00);
        check8("hrst_tx_valid", {7'd0, O_tx_valid}, 8'h00);
        check8("hrst_rx_ready", {7'd0, O_rx_ready}, 8'h00);
        reset_n = 1'b1; bus_idle(); step();
        check8("hrst_rdy_back", {7'd0, O_rx_ready}, 8'h01);
        reg_rd(14'h04, 8'h00, "hrst_rx_count");
        reg_rd(14'h03, 8'h00, "hrst_tx_count");
        I_rx_valid = 1'b1; I_rx_data = 8'hAB; step(); I_rx_valid = 1'b0;
        reg_rd(14'h01, 8'hAB, "hrst_no_stale");
        reg_wr(14'h05, 8'h01);
        step(); step();
        check8("abort_pulse_mid", {7'd0, O_reset}, 8'h01);
        reset_n = 1'b0; step();
        check8("abort_pulse_low", {7'd0, O_reset}, 8'h00);
        check8("abort_rx_ready", {7'd0, O_rx_ready}, 8'h00);
        reset_n = 1'b1; step(); step();
        check8("abort_stays_low", {7'd0, O_reset}, 8'h00);
        check8("abort_rdy_back", {7'd0, O_rx_ready}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
